// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Hazard/stall controller sitting beside the ID stage of a 5-stage pipeline.
// Sequences the PC, IF/ID and ID/EX registers: stalls on load-use hazards,
// holds the pipe while a multi-cycle multiply is in flight, and flushes IF/ID
// on taken branches.
//
// State | meaning
// ------+-----------------------------------------------------------------
// RUN        | normal issue; hazard / mul / branch evaluated here
// LOAD_STALL | extra load-use stall cycles beyond the detection cycle
// MUL_WAIT   | waiting for mul_done (or timeout) with the pipe held
//
// Ports:
//   clk, rst             clock (rising edge), async active-high reset
//   id_Rs, id_Rt         source fields of the instruction in ID
//   id_uses_rt           ID instruction reads Rt
//   ex_mem_read, ex_Rt   instruction in EX is a load, and its destination
//   id_is_mul            ID instruction is a multi-cycle multiply
//   mul_done             multiplier result valid pulse
//   id_branch_taken      branch in ID resolved taken
//   pc_write             PC load enable
//   if_id_write          IF/ID load enable
//   if_id_flush          IF/ID clear
//   id_ex_bubble         ID/EX loads zeroed control signals
//   mul_start            one-cycle multiplier start pulse
//   mul_timeout          sticky multiply timeout flag
//   stall_cycles         saturating count of cycles with pc_write low
module pipeline_hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MUL_TIMEOUT       = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_Rs,
  input  logic [4:0]  id_Rt,
  input  logic        id_uses_rt,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_Rt,
  input  logic        id_is_mul,
  input  logic        mul_done,
  input  logic        id_branch_taken,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        mul_start,
  output logic        mul_timeout,
  output logic [15:0] stall_cycles
);

  localparam logic [1:0] ST_RUN        = 2'd0;
  localparam logic [1:0] ST_LOAD_STALL = 2'd1;
  localparam logic [1:0] ST_MUL_WAIT   = 2'd2;

  localparam logic [3:0]  LD_INIT   = 4'(LOAD_STALL_CYCLES - 1);
  localparam logic [15:0] MUL_LIMIT = 16'(MUL_TIMEOUT);

  logic [1:0]  state_q, state_d;
  logic [3:0]  ld_cnt_q, ld_cnt_d;
  logic [15:0] mul_cnt_q, mul_cnt_d;
  logic        mul_timeout_q, mul_timeout_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;

  logic hazard;
  logic pc_write_c, if_id_write_c, if_id_flush_c, id_ex_bubble_c, mul_start_c;

  // Register 0 is hardwired, so a load targeting it never creates a hazard.
  assign hazard = ex_mem_read && (ex_Rt != 5'd0) &&
                  ((ex_Rt == id_Rs) || (id_uses_rt && (ex_Rt == id_Rt)));

  always_comb begin
    state_d        = state_q;
    ld_cnt_d       = ld_cnt_q;
    mul_cnt_d      = mul_cnt_q;
    mul_timeout_d  = mul_timeout_q;
    pc_write_c     = 1'b1;
    if_id_write_c  = 1'b1;
    id_ex_bubble_c = 1'b0;
    if_id_flush_c  = 1'b0;
    mul_start_c    = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (hazard) begin
          pc_write_c     = 1'b0;
          if_id_write_c  = 1'b0;
          id_ex_bubble_c = 1'b1;
          // The detection cycle is itself the first stall cycle.
          if (LOAD_STALL_CYCLES > 1) begin
            state_d  = ST_LOAD_STALL;
            ld_cnt_d = LD_INIT;
          end
        end else if (id_is_mul) begin
          mul_start_c    = 1'b1;
          pc_write_c     = 1'b0;
          if_id_write_c  = 1'b0;
          id_ex_bubble_c = 1'b1;
          state_d        = ST_MUL_WAIT;
          mul_cnt_d      = 16'd1;
        end else if (id_branch_taken) begin
          if_id_flush_c = 1'b1;
        end
      end

      ST_LOAD_STALL: begin
        pc_write_c     = 1'b0;
        if_id_write_c  = 1'b0;
        id_ex_bubble_c = 1'b1;
        ld_cnt_d       = ld_cnt_q - 4'd1;
        if (ld_cnt_q == 4'd1) begin
          state_d = ST_RUN;
        end
      end

      ST_MUL_WAIT: begin
        if (mul_done) begin
          // Release in the same cycle so the mul advances into EX.
          state_d = ST_RUN;
        end else if (mul_cnt_q == MUL_LIMIT) begin
          // Timeout behaves like a completion so the pipe cannot wedge.
          mul_timeout_d = 1'b1;
          state_d       = ST_RUN;
        end else begin
          pc_write_c     = 1'b0;
          if_id_write_c  = 1'b0;
          id_ex_bubble_c = 1'b1;
          if (mul_cnt_q != 16'hFFFF) begin
            mul_cnt_d = mul_cnt_q + 16'd1;
          end
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase

    stall_cycles_d = stall_cycles_q;
    if (!pc_write_c && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_RUN;
      ld_cnt_q       <= 4'd0;
      mul_cnt_q      <= 16'd0;
      mul_timeout_q  <= 1'b0;
      stall_cycles_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      ld_cnt_q       <= ld_cnt_d;
      mul_cnt_q      <= mul_cnt_d;
      mul_timeout_q  <= mul_timeout_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // Reset overrides the combinational outputs immediately, independent of clk.
  assign pc_write     = pc_write_c && !rst;
  assign if_id_write  = if_id_write_c && !rst;
  assign if_id_flush  = if_id_flush_c && !rst;
  assign id_ex_bubble = id_ex_bubble_c || rst;
  assign mul_start    = mul_start_c && !rst;
  assign mul_timeout  = mul_timeout_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl: two instances (default parameters and
// LOAD_STALL_CYCLES=3 / MUL_TIMEOUT=8) share one stimulus stream; a
// behavioural model predicts each cycle's outputs into a scoreboard queue
// that a separate monitor drains mid-cycle.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  id_Rs = '0, id_Rt = '0, ex_Rt = '0;
  logic        id_uses_rt = 1'b0, ex_mem_read = 1'b0, id_is_mul = 1'b0;
  logic        mul_done = 1'b0, id_branch_taken = 1'b0;

  logic        pc_write_a, if_id_write_a, if_id_flush_a, id_ex_bubble_a, mul_start_a, mul_timeout_a;
  logic [15:0] stall_cycles_a;
  logic        pc_write_b, if_id_write_b, if_id_flush_b, id_ex_bubble_b, mul_start_b, mul_timeout_b;
  logic [15:0] stall_cycles_b;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl u_dut_a (
    .clk(clk), .rst(rst), .id_Rs(id_Rs), .id_Rt(id_Rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_Rt(ex_Rt), .id_is_mul(id_is_mul), .mul_done(mul_done),
    .id_branch_taken(id_branch_taken), .pc_write(pc_write_a), .if_id_write(if_id_write_a),
    .if_id_flush(if_id_flush_a), .id_ex_bubble(id_ex_bubble_a), .mul_start(mul_start_a),
    .mul_timeout(mul_timeout_a), .stall_cycles(stall_cycles_a)
  );

  pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .MUL_TIMEOUT(8)) u_dut_b (
    .clk(clk), .rst(rst), .id_Rs(id_Rs), .id_Rt(id_Rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_Rt(ex_Rt), .id_is_mul(id_is_mul), .mul_done(mul_done),
    .id_branch_taken(id_branch_taken), .pc_write(pc_write_b), .if_id_write(if_id_write_b),
    .if_id_flush(if_id_flush_b), .id_ex_bubble(id_ex_bubble_b), .mul_start(mul_start_b),
    .mul_timeout(mul_timeout_b), .stall_cycles(stall_cycles_b)
  );

  // Output vector layout: {pc_write, if_id_write, if_id_flush, id_ex_bubble,
  //                        mul_start, mul_timeout, stall_cycles[15:0]}
  logic [21:0] out_a, out_b;
  assign out_a = {pc_write_a, if_id_write_a, if_id_flush_a, id_ex_bubble_a,
                  mul_start_a, mul_timeout_a, stall_cycles_a};
  assign out_b = {pc_write_b, if_id_write_b, if_id_flush_b, id_ex_bubble_b,
                  mul_start_b, mul_timeout_b, stall_cycles_b};

  localparam logic [21:0] RESET_OUT = {6'b000100, 16'h0000};

  typedef struct packed {
    int ld_remain;    // stall cycles still owed after the current one
    int mul_elapsed;  // cycles spent waiting on the multiplier so far
    bit in_mul;
    bit timeout;
    int stalls;
  } model_t;

  model_t ma, mb;
  logic [43:0] sb_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(string name, logic [21:0] act, logic [21:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endfunction

  task automatic model_step(input model_t mi, input int n, input int t,
                            output model_t mo, output logic [21:0] e);
    logic pc, ifw, fl, bub, st, hz;
    mo = mi;
    if (rst) begin
      mo = '0;
      e  = RESET_OUT;
    end else begin
      hz  = ex_mem_read && (ex_Rt != 0) &&
            ((ex_Rt == id_Rs) || (id_uses_rt && (ex_Rt == id_Rt)));
      pc  = 1'b1; ifw = 1'b1; fl = 1'b0; bub = 1'b0; st = 1'b0;
      if (mi.ld_remain > 0) begin
        pc = 1'b0; ifw = 1'b0; bub = 1'b1;
        mo.ld_remain = mi.ld_remain - 1;
      end else if (mi.in_mul) begin
        if (mul_done || mi.mul_elapsed >= t) begin
          if (!mul_done) mo.timeout = 1'b1;
          mo.in_mul = 1'b0;
        end else begin
          pc = 1'b0; ifw = 1'b0; bub = 1'b1;
          mo.mul_elapsed = mi.mul_elapsed + 1;
        end
      end else if (hz) begin
        pc = 1'b0; ifw = 1'b0; bub = 1'b1;
        mo.ld_remain = n - 1;
      end else if (id_is_mul) begin
        pc = 1'b0; ifw = 1'b0; bub = 1'b1; st = 1'b1;
        mo.in_mul = 1'b1;
        mo.mul_elapsed = 1;
      end else begin
        fl = id_branch_taken;
      end
      e = {pc, ifw, fl, bub, st, mi.timeout, 16'(mi.stalls)};
      if (!pc && mi.stalls < 65535) mo.stalls = mi.stalls + 1;
    end
  endtask

  task automatic cyc(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                     input logic urt, input logic mr, input logic [4:0] ert,
                     input logic mul, input logic md, input logic br);
    model_t na, nb;
    logic [21:0] ea, eb;
    @(posedge clk);
    #1;
    rst = r; id_Rs = rs; id_Rt = rt; id_uses_rt = urt; ex_mem_read = mr;
    ex_Rt = ert; id_is_mul = mul; mul_done = md; id_branch_taken = br;
    model_step(ma, 1, 64, na, ea);
    model_step(mb, 3, 8, nb, eb);
    ma = na;
    mb = nb;
    sb_q.push_back({ea, eb});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compares the outputs mid-cycle, once the combinational paths settle.
  initial begin
    logic [43:0] e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("dut_a_outputs", out_a, e[43:22]);
        check("dut_b_outputs", out_b, e[21:0]);
      end
    end
  end

  initial begin
    ma = '0;
    mb = '0;
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 1, 1);
    idle(2);
    // load-use on Rs
    cyc(0, 5, 0, 0, 1, 5, 0, 0, 0);
    idle(4);
    // r0 load never stalls
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
    idle(1);
    // Rt match ignored unless Rt is a source
    cyc(0, 1, 7, 0, 1, 7, 0, 0, 0);
    idle(1);
    cyc(0, 1, 7, 1, 1, 7, 0, 0, 0);
    idle(4);
    // branch with hazard, then branch alone
    cyc(0, 5, 0, 0, 1, 5, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(4);
    // multiply completing 4 cycles after start, stray mul_done beforehand
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(3);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(4);
    // multiply with no completion: both instances time out
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(70);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 199) == 0),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 3) == 0));
    end
    idle(4);
    // asynchronous reset in the middle of MUL_WAIT
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(3);
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 0);
    #2;
    check("async_reset_a", out_a, RESET_OUT);
    check("async_reset_b", out_b, RESET_OUT);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    for (int i = 0; i < 100; i++) begin
      cyc(1'b0,
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 3) == 0));
    end
    idle(2);
    repeat (3) @(posedge clk);
    check("scoreboard_drained", 22'(sb_q.size()), 22'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Hazard/stall controller for the 5-stage pipeline. It sequences the PC, the IF/ID register and the ID/EX register: it stalls on load-use hazards, holds the pipe during multi-cycle multiply, and flushes IF/ID on taken branches. It sits beside the ID stage. It drives the write enable and bubble (zero control-signal) inputs of the PC, IF/ID and ID/EX registers.

Parameters:
LOAD_STALL_CYCLES, 1, cycles of stall per load-use hazard (1..15)
MUL_TIMEOUT, 64, max cycles in MUL_WAIT before timeout (2..65535)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
id_Rs  input  5  Rs field of instruction in ID
id_Rt  input  5  Rt field of instruction in ID
id_uses_rt  input  1  ID instruction reads Rt as a source
ex_mem_read  input  1  instruction in EX (ID/EX output) is a load
ex_Rt  input  5  load destination register (ID/EX Rt)
id_is_mul  input  1  ID instruction is a multi-cycle multiply
mul_done  input  1  multiplier result valid (single-cycle pulse)
id_branch_taken  input  1  branch in ID resolved taken
pc_write  output  1  PC load enable
if_id_write  output  1  IF/ID load enable
if_id_flush  output  1  IF/ID clear (takes effect next edge)
id_ex_bubble  output  1  ID/EX loads zero EX/M/WB control signals
mul_start  output  1  one-cycle multiplier start pulse
mul_timeout  output  1  sticky: MUL_WAIT exceeded MUL_TIMEOUT
stall_cycles  output  16  saturating count of cycles with pc_write=0

Behaviour:
- States: RUN, LOAD_STALL, MUL_WAIT. State, counters and mul_timeout are registered. Other outputs are combinational from state and inputs.
- While rst=1: state=RUN, counters=0, mul_timeout=0, stall_cycles=0. Outputs are forced to pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0, mul_start=0.
- hazard = ex_mem_read && ex_Rt!=0 && (ex_Rt==id_Rs || (id_uses_rt && ex_Rt==id_Rt)). Register 0 never causes a hazard.
- RUN, default: pc_write=1, if_id_write=1, id_ex_bubble=0, if_id_flush=0.
- RUN, priority 1, hazard: pc_write=0, if_id_write=0, id_ex_bubble=1.
  - LOAD_STALL_CYCLES=1: stay in RUN.
  - Otherwise: go to LOAD_STALL with ld_cnt=LOAD_STALL_CYCLES-1.
- RUN, priority 2, id_is_mul and no hazard: mul_start=1 for this cycle only, pc_write=0, if_id_write=0, id_ex_bubble=1; go to MUL_WAIT with mul_cnt=1.
- RUN, priority 3, id_branch_taken, no hazard and no mul: if_id_flush=1, pc_write=1. The flush is ignored whenever any stall is active.
- LOAD_STALL: stall outputs held (pc_write=0, if_id_write=0, id_ex_bubble=1); ld_cnt decrements each cycle. When ld_cnt==1, next state is RUN. Total stall is exactly LOAD_STALL_CYCLES cycles, counting the detection cycle.
- MUL_WAIT: stall outputs held; mul_start=0; mul_cnt increments, saturating at 65535.
  - mul_done=1: in the same cycle pc_write=1, if_id_write=1, id_ex_bubble=0; next state is RUN. The mul instruction advances into EX.
  - mul_cnt==MUL_TIMEOUT without mul_done: set mul_timeout (sticky until rst), treat the cycle as mul_done, and return to RUN.
  - mul_done outside MUL_WAIT is ignored.
- id_branch_taken or id_is_mul asserted in LOAD_STALL or MUL_WAIT has no effect. It is re-evaluated in RUN once the stall clears.
- stall_cycles increments on every non-reset cycle with pc_write=0 and saturates at 16'hFFFF.
- Reset asserted mid-stall or mid-MUL_WAIT aborts immediately, asynchronously. No mul_start is generated on exit from reset.

Test Plan:
- Load-use, defaults: ex_mem_read=1, ex_Rt=5, id_Rs=5 for 1 cycle -> exactly 1 cycle with pc_write=0 and id_ex_bubble=1; stall_cycles=1.
- ex_Rt=0 and id_Rs=0 with ex_mem_read=1 -> no stall. ex_Rt=7, id_Rt=7, id_uses_rt=0 -> no stall. Same with id_uses_rt=1 -> stall.
- LOAD_STALL_CYCLES=3, one hazard -> pc_write low exactly 3 consecutive cycles, then RUN; stall_cycles=3.
- id_is_mul=1, mul_done 4 cycles after mul_start -> mul_start is a single pulse; stall held through the mul_done cycle, release on that cycle; mul_timeout stays 0.
- MUL_TIMEOUT=8, mul_done never asserted -> return to RUN after 8 cycles; mul_timeout=1 and stays set until rst.
- id_branch_taken=1 and hazard=1 in the same cycle -> stall only, if_id_flush=0. Next cycle, branch alone -> if_id_flush=1 for 1 cycle.
- Assert rst during MUL_WAIT -> outputs go to reset values without waiting for a clock edge; after release, state is RUN and stall_cycles=0.
